// File: rtl/mainfsm.sv
// Moore control FSM for the multicycle ARM core: fetch/decode/execute/memory/writeback sequencing.
// Optional illegal-opcode trap (UNKNOWN state, Illegal flag) enabled by MAINFSM_ILLEGAL_TRAP_EN.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State,
  output logic       Illegal
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CTRL_W  = 14;

  localparam logic [STATE_W-1:0] FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] MEMADR   = 4'd2;
  localparam logic [STATE_W-1:0] MEMRD    = 4'd3;
  localparam logic [STATE_W-1:0] MEMWB    = 4'd4;
  localparam logic [STATE_W-1:0] MEMWR    = 4'd5;
  localparam logic [STATE_W-1:0] EXECUTER = 4'd6;
  localparam logic [STATE_W-1:0] EXECUTEI = 4'd7;
  localparam logic [STATE_W-1:0] ALUWB    = 4'd8;
  localparam logic [STATE_W-1:0] BRANCH   = 4'd9;
  localparam logic [STATE_W-1:0] UNKNOWN  = 4'd10;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               unused_funct;

  assign unused_funct = ^Funct[4:1];

  // Moore output decode; control word packs
  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal}.
  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [STATE_W-1:0] s);
    logic       irw, adr, npc, regw, memw, br, aluop, ill;
    logic [1:0] srca, srcb, res;
    irw = 1'b0; adr = 1'b0; npc = 1'b0; regw = 1'b0;
    memw = 1'b0; br = 1'b0; aluop = 1'b0; ill = 1'b0;
    srca = 2'b00; srcb = 2'b00; res = 2'b00;
    case (s)
      FETCH: begin
        irw = 1'b1; npc = 1'b1; srca = 2'b01; srcb = 2'b10; res = 2'b10;
      end
      DECODE: begin
        srca = 2'b01; srcb = 2'b10; res = 2'b10;
      end
      MEMADR:   srcb = 2'b01;
      MEMRD:    adr = 1'b1;
      MEMWB: begin
        res = 2'b01; regw = 1'b1;
      end
      MEMWR: begin
        adr = 1'b1; memw = 1'b1;
      end
      EXECUTER: aluop = 1'b1;
      EXECUTEI: begin
        srcb = 2'b01; aluop = 1'b1;
      end
      ALUWB:    regw = 1'b1;
      BRANCH: begin
        srca = 2'b10; srcb = 2'b01; res = 2'b10; br = 1'b1;
      end
`ifdef MAINFSM_ILLEGAL_TRAP_EN
      UNKNOWN:  ill = 1'b1;
`endif
      default: ;
    endcase
    return {irw, adr, srca, srcb, res, npc, regw, memw, br, aluop, ill};
  endfunction

  // Next state; unreachable codes fall back to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
          default: state_d = UNKNOWN;
`else
          default: state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
      UNKNOWN:  state_d = UNKNOWN;
`endif
      default:  state_d = FETCH;
    endcase
    ctrl_d = decode_ctrl(state_d);
  end

  // Control word is registered alongside the state so outputs always match decode(State).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      ctrl_q  <= decode_ctrl(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
          NextPC, RegW, MemW, Branch, ALUOp, Illegal} = ctrl_q;
  assign State = state_q;

endmodule
